// File: rtl/imem_port_ctrl.sv
// Single-port SRAM controller shared by instruction fetch and MEM-stage loads/stores.
// Data accesses win; the PC is stalled and NOPs are fed to decode meanwhile. Optional counters: IMEM_PERF_CNT_EN.
module imem_port_ctrl #(
   parameter int          SRAM_AW   = 18,
   parameter logic [15:0] NOP_INSTR = 16'h0800,
   parameter int          RD_WAIT   = 0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [15:0]        if_addr_i,
   input  logic               flush_i,
   output logic [15:0]        if_instr_o,
   output logic               if_valid_o,
   output logic               stall_pc_o,
   input  logic               mem_req_i,
   input  logic               mem_we_i,
   input  logic [15:0]        mem_addr_i,
   input  logic [15:0]        mem_wdata_i,
   output logic [15:0]        mem_rdata_o,
   output logic               mem_done_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   input  logic [15:0]        sram_dq_i,
   output logic [15:0]        sram_dq_o,
   output logic               sram_dq_oe_o,
   output logic               sram_ce_n_o,
   output logic               sram_oe_n_o,
   output logic               sram_we_n_o
`ifdef IMEM_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cnt_o,
   output logic [15:0]        fetch_cnt_o
`endif
);

   typedef enum logic [2:0] {RST_S, IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

   localparam logic [2:0] RD_WAIT_C = 3'(RD_WAIT);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [15:0] rdata_q, rdata_d;
   logic        fetch, rd_last, wr_any;
   logic [15:0] addr_sel;

   assign fetch   = (state_q == IDLE) && !mem_req_i;
   assign rd_last = (state_q == RD) && (cnt_q == RD_WAIT_C);
   assign wr_any  = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      rdata_d = rdata_q;
      case (state_q)
         RST_S: state_d = IDLE;
         IDLE: begin
            if (mem_req_i) begin
               state_d = mem_we_i ? WR_SETUP : RD;
               cnt_d   = 3'd0;
            end else if (!flush_i) begin
               instr_d = sram_dq_i;
               valid_d = 1'b1;
            end
         end
         RD: begin
            cnt_d = cnt_q + 3'd1;
            if (rd_last) begin
               rdata_d = sram_dq_i;
               state_d = IDLE;
            end
         end
         WR_SETUP: state_d = WR_PULSE;
         WR_PULSE: state_d = WR_HOLD;
         WR_HOLD:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // SRAM strobes decode straight from state so a reset kills them without waiting for a clock
   assign addr_sel     = fetch ? if_addr_i : mem_addr_i;
   assign sram_addr_o  = SRAM_AW'(addr_sel);
   assign sram_ce_n_o  = !(fetch || (state_q == RD) || wr_any);
   assign sram_oe_n_o  = !(fetch || (state_q == RD));
   assign sram_we_n_o  = (state_q != WR_PULSE);
   assign sram_dq_oe_o = wr_any;
   assign sram_dq_o    = mem_wdata_i;

   assign stall_pc_o  = !fetch;
   assign mem_done_o  = rd_last || (state_q == WR_HOLD);
   assign mem_rdata_o = rd_last ? sram_dq_i : rdata_q;
   assign if_instr_o  = instr_q;
   assign if_valid_o  = valid_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= RST_S;
         cnt_q   <= 3'd0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef IMEM_PERF_CNT_EN
   logic [15:0] stall_cnt_q, fetch_cnt_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stall_cnt_q <= 16'h0000;
         fetch_cnt_q <= 16'h0000;
      end else begin
         if (stall_pc_o && (state_q != RST_S)) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (valid_d) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Directed bench for imem_port_ctrl with a behavioural asynchronous-read SRAM.
// Define IMEM_PERF_CNT_EN consistently with the RTL build to exercise the counters.
module tb_imem_port_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] if_addr_i = 16'h0000;
   logic        flush_i = 1'b0;
   logic [15:0] if_instr_o;
   logic        if_valid_o, stall_pc_o;
   logic        mem_req_i = 1'b0, mem_we_i = 1'b0;
   logic [15:0] mem_addr_i = 16'h0000, mem_wdata_i = 16'h0000;
   logic [15:0] mem_rdata_o;
   logic        mem_done_o;
   logic [17:0] sram_addr_o;
   logic [15:0] sram_dq_i, sram_dq_o;
   logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
`ifdef IMEM_PERF_CNT_EN
   logic [15:0] stall_cnt_o, fetch_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   logic [15:0] sram_mem [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = 16'h0000, pre_data = 16'h0000;

   imem_port_ctrl dut (
      .CLK(CLK), .RST(RST),
      .if_addr_i(if_addr_i), .flush_i(flush_i),
      .if_instr_o(if_instr_o), .if_valid_o(if_valid_o), .stall_pc_o(stall_pc_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
      .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
      .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o),
      .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o)
`ifdef IMEM_PERF_CNT_EN
      , .stall_cnt_o(stall_cnt_o), .fetch_cnt_o(fetch_cnt_o)
`endif
   );

   always #5 CLK = ~CLK;

   assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[15:0]] : 16'h0000;

   always @(posedge CLK) begin
      if (pre_we) sram_mem[pre_addr] <= pre_data;
      else if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) sram_mem[sram_addr_o[15:0]] <= sram_dq_o;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      step();
      pre_we   = 1'b0;
   endtask

   task automatic test_reset();
      preload(16'h0000, 16'h1234);
      preload(16'h8000, 16'hBEEF);
      preload(16'h0040, 16'h7777);
      preload(16'h9003, 16'h1111);
      total++; if (if_instr_o !== 16'h0800) begin bad++; $display("FAIL rst_instr got=%h exp=0800", if_instr_o); end
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid_o); end
      total++; if (mem_rdata_o !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", mem_rdata_o); end
      total++; if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o} !== 4'b1110) begin
         bad++; $display("FAIL rst_strobes got=%b exp=1110", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}); end
      RST = 1'b1;
      #1;
      total++; if (stall_pc_o !== 1'b1) begin bad++; $display("FAIL rsts_stall got=%b exp=1", stall_pc_o); end
      step();
      total++; if (stall_pc_o !== 1'b0) begin bad++; $display("FAIL fetch_stall got=%b exp=0", stall_pc_o); end
      total++; if ({sram_ce_n_o, sram_oe_n_o, sram_addr_o} !== {2'b00, 18'h00000}) begin
         bad++; $display("FAIL fetch_strobes got=%b%b/%h exp=00/00000", sram_ce_n_o, sram_oe_n_o, sram_addr_o); end
      step();
      total++; if ({if_valid_o, if_instr_o} !== {1'b1, 16'h1234}) begin
         bad++; $display("FAIL fetch_word got=%b/%h exp=1/1234", if_valid_o, if_instr_o); end
   endtask

   task automatic do_load(input logic [15:0] a, input logic [15:0] exp_d, input string nm);
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a;
      #1;
      total++; if ({stall_pc_o, sram_oe_n_o, mem_done_o} !== 3'b110) begin
         bad++; $display("FAIL %s_idle got=%b exp=110", nm, {stall_pc_o, sram_oe_n_o, mem_done_o}); end
      step();
      total++; if ({stall_pc_o, mem_done_o, mem_rdata_o} !== {2'b11, exp_d}) begin
         bad++; $display("FAIL %s_rd got=%b%b/%h exp=11/%h", nm, stall_pc_o, mem_done_o, mem_rdata_o, exp_d); end
      total++; if ({if_valid_o, if_instr_o, sram_addr_o, sram_dq_oe_o} !== {1'b0, 16'h0800, 2'b00, a, 1'b0}) begin
         bad++; $display("FAIL %s_rdsig got=%b/%h/%h/%b exp=0/0800/%h/0", nm, if_valid_o, if_instr_o, sram_addr_o, sram_dq_oe_o, a); end
      step();
      mem_req_i = 1'b0;
      #1;
      total++; if ({stall_pc_o, mem_done_o, mem_rdata_o} !== {2'b00, exp_d}) begin
         bad++; $display("FAIL %s_after got=%b%b/%h exp=00/%h", nm, stall_pc_o, mem_done_o, mem_rdata_o, exp_d); end
      total++; if ({if_valid_o, if_instr_o} !== {1'b0, 16'h0800}) begin
         bad++; $display("FAIL %s_nop got=%b/%h exp=0/0800", nm, if_valid_o, if_instr_o); end
      step();
   endtask

   task automatic test_load();
      do_load(16'h8000, 16'hBEEF, "load");
   endtask

   task automatic test_store();
      int we_lo = 0, oe_hi = 0, oen_lo = 0, done_n = 0;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h9001; mem_wdata_i = 16'h5A5A;
      for (int c = 0; c < 4; c++) begin
         #1;
         we_lo  += (sram_we_n_o == 1'b0) ? 1 : 0;
         oe_hi  += (sram_dq_oe_o == 1'b1) ? 1 : 0;
         oen_lo += (sram_oe_n_o == 1'b0) ? 1 : 0;
         done_n += (mem_done_o == 1'b1) ? 1 : 0;
         if (c == 2) begin
            total++; if ({sram_we_n_o, sram_dq_o} !== {1'b0, 16'h5A5A}) begin
               bad++; $display("FAIL st_pulse got=%b/%h exp=0/5A5A", sram_we_n_o, sram_dq_o); end
         end
         if (c == 3) begin
            total++; if ({mem_done_o, sram_we_n_o} !== 2'b11) begin
               bad++; $display("FAIL st_hold got=%b exp=11", {mem_done_o, sram_we_n_o}); end
         end
         step();
      end
      mem_req_i = 1'b0; mem_we_i = 1'b0;
      total++; if ({we_lo, oe_hi, oen_lo, done_n} !== {32'd1, 32'd3, 32'd0, 32'd1}) begin
         bad++; $display("FAIL st_counts got=we%0d oe%0d oen%0d done%0d exp=we1 oe3 oen0 done1", we_lo, oe_hi, oen_lo, done_n); end
      step();
      do_load(16'h9001, 16'h5A5A, "ldback");
   endtask

   task automatic test_back_to_back();
      int stalls = 0, valids = 0;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'h8000;
      #1; stalls += stall_pc_o ? 1 : 0;
      step(); stalls += stall_pc_o ? 1 : 0; valids += if_valid_o ? 1 : 0;
      total++; if ({mem_done_o, mem_rdata_o} !== {1'b1, 16'hBEEF}) begin
         bad++; $display("FAIL b2b_ld got=%b/%h exp=1/BEEF", mem_done_o, mem_rdata_o); end
      step();
      mem_we_i = 1'b1; mem_addr_i = 16'h9002; mem_wdata_i = 16'hC3C3;
      #1; stalls += stall_pc_o ? 1 : 0; valids += if_valid_o ? 1 : 0;
      for (int c = 0; c < 3; c++) begin
         step(); stalls += stall_pc_o ? 1 : 0; valids += if_valid_o ? 1 : 0;
      end
      total++; if (mem_done_o !== 1'b1) begin bad++; $display("FAIL b2b_st_done got=%b exp=1", mem_done_o); end
      step();
      mem_req_i = 1'b0; mem_we_i = 1'b0;
      #1; valids += if_valid_o ? 1 : 0;
      total++; if ({stalls, valids, 31'd0, stall_pc_o} !== {32'd6, 32'd0, 32'd0}) begin
         bad++; $display("FAIL b2b_stall got=stalls%0d valids%0d now%b exp=stalls6 valids0 now0", stalls, valids, stall_pc_o); end
      step();
   endtask

   task automatic test_flush();
      if_addr_i = 16'h0040; flush_i = 1'b1;
      #1;
      total++; if (stall_pc_o !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_pc_o); end
      step();
      flush_i = 1'b0;
      total++; if ({if_valid_o, if_instr_o} !== {1'b0, 16'h0800}) begin
         bad++; $display("FAIL flush_word got=%b/%h exp=0/0800", if_valid_o, if_instr_o); end
      step();
      total++; if ({if_valid_o, if_instr_o} !== {1'b1, 16'h7777}) begin
         bad++; $display("FAIL unflush_word got=%b/%h exp=1/7777", if_valid_o, if_instr_o); end
      if_addr_i = 16'h0000;
      step();
   endtask

   task automatic test_reset_mid_store();
      int dones = 0;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h9003; mem_wdata_i = 16'hAAAA;
      #1; dones += mem_done_o ? 1 : 0;
      step(); dones += mem_done_o ? 1 : 0;
      step(); dones += mem_done_o ? 1 : 0;
      total++; if (sram_we_n_o !== 1'b0) begin bad++; $display("FAIL mid_pulse got=%b exp=0", sram_we_n_o); end
      #2;
      RST = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
      #1;
      total++; if ({sram_we_n_o, sram_ce_n_o, sram_oe_n_o, sram_dq_oe_o, stall_pc_o} !== 5'b11101) begin
         bad++; $display("FAIL mid_abort got=%b exp=11101", {sram_we_n_o, sram_ce_n_o, sram_oe_n_o, sram_dq_oe_o, stall_pc_o}); end
`ifdef IMEM_PERF_CNT_EN
      total++; if ({stall_cnt_o, fetch_cnt_o} !== 32'h0) begin
         bad++; $display("FAIL perf_rst got=%h/%h exp=0000/0000", stall_cnt_o, fetch_cnt_o); end
`endif
      for (int c = 0; c < 2; c++) begin
         step(); dones += mem_done_o ? 1 : 0;
      end
      RST = 1'b1;
      #1; dones += mem_done_o ? 1 : 0;
      step();
      total++; if (dones !== 0) begin bad++; $display("FAIL mid_done got=%0d exp=0", dones); end
      do_load(16'h9003, 16'h1111, "noabortwr");
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_flush();
      test_reset_mid_store();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
